vslc_prog_responder: RTL and testbench

- Program-memory responder on the far side of the vslc core's instruction-fetch interface.
- The core issues a one-cycle address strobe with an address; this block returns the stored instruction word on a fixed one-cycle latency.
- The program is loaded bit-serially from dedicated input pins through a single-clock load port.
- It sits in the tt_um top level beside the core and consumes the core's address strobe.

---
 rtl/vslc_prog_responder.sv | 108 ++++++++++
 tb/tb_vslc_prog_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vslc_prog_responder.sv
// Program-memory responder for the vslc instruction-fetch port.
// Serves words with one-cycle latency; program is loaded bit-serially, MSB first.
module vslc_prog_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_strobe,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              load_en,
    input  logic              load_bit,
    input  logic              load_bit_valid,
    output logic              busy,
    output logic [ADDR_W:0]   prog_len,
    output logic              overflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BCW   = $clog2(DATA_W);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_W - 1);
    localparam logic [ADDR_W:0] FULL     = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {SERVE, LOAD} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-2:0] r_shift;
    logic [BCW-1:0]    r_bitcnt;
    logic [ADDR_W:0]   r_len;
    logic              r_ovf;
    logic              r_busy;
    logic [DATA_W-1:0] r_instr;
    logic              r_valid;

    logic              w_full;
    logic              w_hit;
    logic [DATA_W-1:0] w_word;

    assign w_full = (r_len == FULL);
    assign w_hit  = ({1'b0, addr} < r_len);
    assign w_word = {r_shift, load_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SERVE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_len    <= '0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            // Response reflects the state during the strobe cycle; LOAD always answers NOP.
            r_valid <= addr_strobe;
            if (addr_strobe)
                r_instr <= (r_state == SERVE && w_hit) ? r_mem[addr] : '0;

            case (r_state)
                SERVE: begin
                    if (load_en) begin
                        r_state  <= LOAD;
                        r_busy   <= 1'b1;
                        r_len    <= '0;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                        r_ovf    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_bit_valid) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_shift <= w_word[DATA_W-2:0];
                            if (r_bitcnt == LAST_BIT) begin
                                r_mem[r_len[ADDR_W-1:0]] <= w_word;
                                r_len    <= r_len + 1'b1;
                                r_bitcnt <= '0;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                    // Leaving LOAD drops any partially shifted word.
                    if (!load_en) begin
                        r_state  <= SERVE;
                        r_busy   <= 1'b0;
                        r_bitcnt <= '0;
                    end
                end
                default: begin
                    r_state <= SERVE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign busy        = r_busy;
    assign prog_len    = r_len;
    assign overflow    = r_ovf;
endmodule

// File: tb/tb_vslc_prog_responder.sv
// Directed bench for vslc_prog_responder: behavioural model checked every cycle
// plus literal expectations on fetches, load counts and reset.
module tb_vslc_prog_responder;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          addr_strobe = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          load_en = 1'b0;
    logic          load_bit = 1'b0;
    logic          load_bit_valid = 1'b0;
    logic          busy;
    logic [AW:0]   prog_len;
    logic          overflow;

    int n_vec = 0;
    int n_bad = 0;

    vslc_prog_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_strobe(addr_strobe), .addr(addr),
        .instr(instr), .instr_valid(instr_valid),
        .load_en(load_en), .load_bit(load_bit), .load_bit_valid(load_bit_valid),
        .busy(busy), .prog_len(prog_len), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: a byte array, a word count, and a bit accumulator.
    logic [7:0] m_mem [16];
    int         m_len = 0;
    int         m_nbits = 0;
    logic [7:0] m_acc = '0;
    bit         m_load = 0;
    bit         m_ovf = 0;
    bit         m_valid = 0;
    logic [7:0] m_instr = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_len = 0; m_nbits = 0; m_acc = '0;
            m_load = 0; m_ovf = 0; m_valid = 0; m_instr = '0;
        end else begin
            m_valid = addr_strobe;
            if (addr_strobe)
                m_instr = (!m_load && int'(addr) < m_len) ? m_mem[addr] : 8'h00;
            if (!m_load) begin
                if (load_en) begin
                    m_load = 1; m_len = 0; m_nbits = 0; m_ovf = 0;
                end
            end else begin
                if (load_bit_valid) begin
                    if (m_len == 16) begin
                        m_ovf = 1;
                    end else begin
                        m_acc = {m_acc[6:0], load_bit};
                        m_nbits++;
                        if (m_nbits == 8) begin
                            m_mem[m_len] = m_acc;
                            m_len++;
                            m_nbits = 0;
                        end
                    end
                end
                if (!load_en) begin
                    m_load = 0; m_nbits = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", 32'(instr_valid), 32'(m_valid));
            chk("m_instr", 32'(instr), 32'(m_instr));
            chk("m_busy", 32'(busy), 32'(m_load));
            chk("m_len", 32'(prog_len), 32'(m_len));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic fetch(input logic [AW-1:0] a, input logic [7:0] exp);
        @(posedge clk); #2;
        addr_strobe = 1'b1; addr = a; load_bit_valid = 1'b0;
        @(posedge clk); #2;
        addr_strobe = 1'b0;
        chk("fetch_valid", 32'(instr_valid), 32'd1);
        chk("fetch_instr", 32'(instr), 32'(exp));
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #2;
        load_en = 1'b1; load_bit_valid = 1'b1; load_bit = b;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic enter_load();
        @(posedge clk); #2;
        load_en = 1'b1; load_bit_valid = 1'b0;
        @(posedge clk); #2;
        chk("enter_busy", 32'(busy), 32'd1);
    endtask

    task automatic exit_load();
        @(posedge clk); #2;
        load_en = 1'b0; load_bit_valid = 1'b0;
        @(posedge clk); #2;
        chk("exit_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] seq [4];
        logic [7:0] w;
        seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'hA5; seq[3] = 8'h3C;

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len", 32'(prog_len), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Empty program answers NOP
        fetch(4'd3, 8'h00);
        chk("empty_len", 32'(prog_len), 32'd0);

        // Two-word load
        enter_load();
        send_word(8'hA5);
        send_word(8'h3C);
        exit_load();
        chk("two_len", 32'(prog_len), 32'd2);
        fetch(4'd0, 8'hA5);
        fetch(4'd1, 8'h3C);
        fetch(4'd2, 8'h00);

        // Back-to-back strobes 0,1,0,1
        @(posedge clk); #2;
        addr_strobe = 1'b1; addr = 4'd0;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #2;
            chk("b2b_valid", 32'(instr_valid), 32'd1);
            chk("b2b_instr", 32'(instr), 32'(seq[i-1]));
            addr = AW'(i % 2);
        end
        @(posedge clk); #2;
        addr_strobe = 1'b0;
        chk("b2b_valid", 32'(instr_valid), 32'd1);
        chk("b2b_instr", 32'(instr), 32'(seq[3]));
        @(posedge clk); #2;
        chk("b2b_drop", 32'(instr_valid), 32'd0);
        chk("b2b_hold", 32'(instr), 32'h3C);

        // Strobe during LOAD answers NOP even for a written word
        enter_load();
        send_word(8'h77);
        fetch(4'd0, 8'h00);
        chk("load_busy", 32'(busy), 32'd1);
        exit_load();
        chk("one_len", 32'(prog_len), 32'd1);
        fetch(4'd0, 8'h77);
        @(posedge clk); #2;
        chk("hold_valid", 32'(instr_valid), 32'd0);
        chk("hold_instr", 32'(instr), 32'h77);

        // Fill memory, then overflow
        enter_load();
        for (int i = 0; i < 16; i++) begin
            w = 8'h5A ^ 8'(i * 19);
            send_word(w);
        end
        send_word(8'hFF);
        exit_load();
        chk("full_len", 32'(prog_len), 32'd16);
        chk("full_ovf", 32'(overflow), 32'd1);
        fetch(4'd0, 8'h5A);
        fetch(4'd15, 8'h47);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        enter_load();
        chk("reent_ovf", 32'(overflow), 32'd0);
        chk("reent_len", 32'(prog_len), 32'd0);
        exit_load();
        fetch(4'd0, 8'h00);

        // Partial word discarded
        enter_load();
        send_word(8'h11);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        exit_load();
        chk("part_len", 32'(prog_len), 32'd1);
        fetch(4'd1, 8'h00);
        fetch(4'd0, 8'h11);

        // Async reset mid-load with a response pending
        enter_load();
        send_word(8'hC3);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(posedge clk); #2;
        load_bit_valid = 1'b0; addr_strobe = 1'b1; addr = 4'd0;
        @(posedge clk); #2;
        addr_strobe = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", 32'(instr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_len", 32'(prog_len), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        load_en = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        fetch(4'd0, 8'h00);
        chk("post_len", 32'(prog_len), 32'd0);

        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
